// File: rtl/fila_pkg.sv
// Shared definitions for the instruction queue: fetch FSM state encoding
// and default parameter values used by the top module and storage.
package fila_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } fila_estado_t;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_RESET_PC = 0;

endpackage

// File: rtl/fila_armazenamento.sv
// Queue storage: DEPTH x DATA_W array with one write port and one
// registered read port. The read register is the dispatched instruction,
// so it clears on reset and holds whenever no read is requested.
module fila_armazenamento
  import fila_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [PW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [PW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_data_r;

  // Array write; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holds its value when no read is requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/fila_instrucoes_parametrizada.sv
// Parameterised instruction fetch queue. A three-state fetch FSM
// (FETCH/HOLD/FLUSH) reads instruction memory with one-cycle latency,
// never issuing more reads than there are free slots (stored + in flight).
// Flush empties the queue, drops the pending response and redirects the PC.
// Optional macro FILA_STATS_EN adds saturating pop statistics outputs.
module fila_instrucoes_parametrizada
  import fila_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int RESET_PC = DEF_RESET_PC,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int PW      = $clog2(DEPTH)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Pop,
  input  logic              Flush,
  input  logic [ADDR_W-1:0] Flush_PC,
  output logic              Mem_Rd,
  output logic [ADDR_W-1:0] Mem_Addr,
  input  logic [DATA_W-1:0] Mem_Data,
  output logic [DATA_W-1:0] Instrucao_Despachada,
  output logic              Valid_Out,
  output logic              Full,
  output logic              Empty,
  output logic [CW-1:0]     Count
`ifdef FILA_STATS_EN
  ,
  output logic [31:0]       Pop_Total,
  output logic [31:0]       Pop_Vazio
`endif
);

  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);

  fila_estado_t      state_r;
  fila_estado_t      state_next_s;
  logic [ADDR_W-1:0] pc_r;
  logic [PW-1:0]     head_r;
  logic [PW-1:0]     tail_r;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_next_s;
  logic [CW:0]       occ_next_s;
  logic              inflight_r;
  logic              inflight_next_s;
  logic              valid_r;
  logic              full_r;
  logic              empty_r;
  logic              mem_rd_s;
  logic              wr_s;
  logic              pop_s;

  // Datapath control: read issue, accepted write, successful pop, next count.
  always_comb begin
    mem_rd_s        = 1'b0;
    wr_s            = 1'b0;
    pop_s           = 1'b0;
    inflight_next_s = 1'b0;
    count_next_s    = count_r;
    // Reset gates the strobe so no read is issued while reset is held.
    if ((state_r == FETCH) && !Reset) begin
      mem_rd_s = 1'b1;
    end else begin
      mem_rd_s = 1'b0;
    end
    // A response arriving in a flush cycle is discarded with the contents.
    wr_s            = inflight_r & ~Flush;
    pop_s           = Pop & ~empty_r & ~Flush;
    inflight_next_s = mem_rd_s & ~Flush;
    if (Flush) begin
      count_next_s = {CW{1'b0}};
    end else begin
      case ({wr_s, pop_s})
        2'b10:   count_next_s = count_r + CW'(1);
        2'b01:   count_next_s = count_r - CW'(1);
        default: count_next_s = count_r;
      endcase
    end
    occ_next_s = {1'b0, count_next_s} + {{CW{1'b0}}, inflight_next_s};
  end

  // Fetch FSM next state: FETCH exactly when a read can issue next cycle.
  always_comb begin
    state_next_s = state_r;
    if (Flush) begin
      state_next_s = FLUSH;
    end else begin
      case (state_r)
        FLUSH:       state_next_s = FETCH;
        FETCH, HOLD: state_next_s = (occ_next_s < DEPTH_OCC) ? FETCH : HOLD;
        default:     state_next_s = FETCH;
      endcase
    end
  end

  // State, PC, pointers, occupancy and status flags.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r    <= FETCH;
      pc_r       <= ADDR_W'(RESET_PC);
      head_r     <= {PW{1'b0}};
      tail_r     <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      inflight_r <= 1'b0;
      valid_r    <= 1'b0;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      count_r    <= count_next_s;
      inflight_r <= inflight_next_s;
      valid_r    <= pop_s;
      empty_r    <= (count_next_s == {CW{1'b0}});
      full_r     <= (count_next_s == DEPTH_CNT);
      if (Flush) begin
        pc_r   <= Flush_PC;
        head_r <= {PW{1'b0}};
        tail_r <= {PW{1'b0}};
      end else begin
        if (mem_rd_s) begin
          pc_r <= pc_r + ADDR_W'(1);
        end
        if (wr_s) begin
          tail_r <= tail_r + PW'(1);
        end
        if (pop_s) begin
          head_r <= head_r + PW'(1);
        end
      end
    end
  end

  fila_armazenamento #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_armazenamento (
    .clk     (Clock),
    .rst     (Reset),
    .wr_en   (wr_s),
    .wr_addr (tail_r),
    .wr_data (Mem_Data),
    .rd_en   (pop_s),
    .rd_addr (head_r),
    .rd_data (Instrucao_Despachada)
  );

  assign Mem_Rd    = mem_rd_s;
  assign Mem_Addr  = pc_r;
  assign Valid_Out = valid_r;
  assign Full      = full_r;
  assign Empty     = empty_r;
  assign Count     = count_r;

`ifdef FILA_STATS_EN
  logic [31:0] pop_total_r;
  logic [31:0] pop_vazio_r;

  // Saturating pop statistics; cleared only by reset, kept across flush.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pop_total_r <= 32'd0;
      pop_vazio_r <= 32'd0;
    end else begin
      if (pop_s && (pop_total_r != 32'hFFFF_FFFF)) begin
        pop_total_r <= pop_total_r + 32'd1;
      end
      if (Pop && empty_r && (pop_vazio_r != 32'hFFFF_FFFF)) begin
        pop_vazio_r <= pop_vazio_r + 32'd1;
      end
    end
  end

  assign Pop_Total = pop_total_r;
  assign Pop_Vazio = pop_vazio_r;
`endif

endmodule
